// File: rtl/sram_pkg.sv
// Shared types and helpers for the parametrised 1RW+1R SRAM model.
package sram_pkg;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } init_state_e;

    // Widest word the lane merge can handle; callers zero-extend and truncate.
    localparam int SRAM_MAX_W = 1024;

    function automatic int num_wmasks(input int data_width, input int gran);
        return data_width / gran;
    endfunction

    function automatic int ram_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic logic [SRAM_MAX_W-1:0] lane_merge(
        input logic [SRAM_MAX_W-1:0] old_word,
        input logic [SRAM_MAX_W-1:0] new_word,
        input logic [SRAM_MAX_W-1:0] mask,
        input int                    gran
    );
        logic [SRAM_MAX_W-1:0] merged;
        merged = old_word;
        if (gran > 0) begin
            for (int i = 0; i < SRAM_MAX_W; i++) begin
                if (mask[i / gran]) merged[i] = new_word[i];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_1rw1r_param_if.sv
// Request/response bundle for the 1RW+1R SRAM; the RAM sits on the slave side.
interface sram_1rw1r_param_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_WMASKS = 4
);
    logic                  init_done;
    logic                  csb0;
    logic                  web0;
    logic [NUM_WMASKS-1:0] wmask0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] dout0;
    logic                  dout0_vld;
    logic                  csb1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] dout1;
    logic                  dout1_vld;
    logic                  collision;

    modport master (
        output csb0, web0, wmask0, addr0, din0, csb1, addr1,
        input  init_done, dout0, dout0_vld, dout1, dout1_vld, collision
    );

    modport slave (
        input  csb0, web0, wmask0, addr0, din0, csb1, addr1,
        output init_done, dout0, dout0_vld, dout1, dout1_vld, collision
    );
endinterface

// File: rtl/sram_init_sweeper.sv
// Post-reset clear sequencer: walks every address writing zero, then raises init_done.
module sram_init_sweeper
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk0,
    input  logic                  rstb0,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  init_done
);

    init_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  init_done_q, init_done_d;

    // Without clearing, the CLEAR state lasts exactly one cycle and writes nothing.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_CLEAR: begin
                if ((CLEAR_ON_RESET == 0) || (ptr_q == '1)) begin
                    state_d     = ST_READY;
                    ptr_d       = '0;
                    init_done_d = 1'b1;
                end else begin
                    ptr_d = ptr_q + ADDR_WIDTH'(1);
                end
            end
            ST_READY: init_done_d = 1'b1;
            default:  state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk0) begin
        if (!rstb0) begin
            state_q     <= ST_CLEAR;
            ptr_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            init_done_q <= init_done_d;
        end
    end

    assign clr_we    = (state_q == ST_CLEAR) && (CLEAR_ON_RESET != 0);
    assign clr_addr  = ptr_q;
    assign init_done = init_done_q;

endmodule

// File: rtl/sram_1rw1r_param.sv
// Parametrised single-clock 1RW+1R SRAM with clear-on-reset, lane masks and 1/2-cycle reads.
module sram_1rw1r_param
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int WMASK_GRAN     = 8,
    parameter int READ_LATENCY   = 1,
    parameter int WR_FWD         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic               clk0,
    input  logic               rstb0,
    sram_1rw1r_param_if.slave  bus
);

    localparam int NUM_WMASKS = num_wmasks(DATA_WIDTH, WMASK_GRAN);
    localparam int RAM_DEPTH  = ram_depth(ADDR_WIDTH);

    if ((DATA_WIDTH % WMASK_GRAN) != 0) begin : g_bad_gran
        $error("DATA_WIDTH must be a multiple of WMASK_GRAN");
    end
    if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
        $error("READ_LATENCY must be 1 or 2");
    end

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  init_done;

    sram_init_sweeper #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_sweeper (
        .clk0      (clk0),
        .rstb0     (rstb0),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .init_done (init_done)
    );

    logic                  wr0, rd0, rd1, hit;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic [DATA_WIDTH-1:0] s1_data0_q, s1_data0_d, s1_data1_q, s1_data1_d;
    logic                  s1_vld0_q, s1_vld0_d, s1_vld1_q, s1_vld1_d, s1_col_q, s1_col_d;
    logic [DATA_WIDTH-1:0] s2_data0_q, s2_data0_d, s2_data1_q, s2_data1_d;
    logic                  s2_vld0_q, s2_vld0_d, s2_vld1_q, s2_vld1_d, s2_col_q, s2_col_d;

    // Stage 1 captures at the request edge; stage 2 only advances on a valid word so dout holds.
    always_comb begin
        wr0       = rstb0 && init_done && !bus.csb0 && !bus.web0;
        rd0       = rstb0 && init_done && !bus.csb0 && bus.web0;
        rd1       = rstb0 && init_done && !bus.csb1;
        hit       = wr0 && rd1 && (bus.addr0 == bus.addr1);
        wr_merged = DATA_WIDTH'(lane_merge(SRAM_MAX_W'(mem[bus.addr0]), SRAM_MAX_W'(bus.din0),
                                           SRAM_MAX_W'(bus.wmask0), WMASK_GRAN));

        s1_vld0_d  = rd0;
        s1_data0_d = rd0 ? mem[bus.addr0] : s1_data0_q;
        s1_vld1_d  = rd1;
        s1_col_d   = hit;
        s1_data1_d = s1_data1_q;
        if (rd1) s1_data1_d = (hit && (WR_FWD != 0)) ? wr_merged : mem[bus.addr1];

        s2_vld0_d  = s1_vld0_q;
        s2_data0_d = s1_vld0_q ? s1_data0_q : s2_data0_q;
        s2_vld1_d  = s1_vld1_q;
        s2_col_d   = s1_col_q;
        s2_data1_d = s1_vld1_q ? s1_data1_q : s2_data1_q;
    end

    // The array itself has no reset; the sweeper zeroes it when enabled.
    always_ff @(posedge clk0) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr0) begin
            mem[bus.addr0] <= wr_merged;
        end
    end

    always_ff @(posedge clk0) begin
        if (!rstb0) begin
            s1_data0_q <= '0;
            s1_vld0_q  <= 1'b0;
            s1_data1_q <= '0;
            s1_vld1_q  <= 1'b0;
            s1_col_q   <= 1'b0;
            s2_data0_q <= '0;
            s2_vld0_q  <= 1'b0;
            s2_data1_q <= '0;
            s2_vld1_q  <= 1'b0;
            s2_col_q   <= 1'b0;
        end else begin
            s1_data0_q <= s1_data0_d;
            s1_vld0_q  <= s1_vld0_d;
            s1_data1_q <= s1_data1_d;
            s1_vld1_q  <= s1_vld1_d;
            s1_col_q   <= s1_col_d;
            s2_data0_q <= s2_data0_d;
            s2_vld0_q  <= s2_vld0_d;
            s2_data1_q <= s2_data1_d;
            s2_vld1_q  <= s2_vld1_d;
            s2_col_q   <= s2_col_d;
        end
    end

    assign bus.init_done = init_done;
    assign bus.dout0     = (READ_LATENCY == 2) ? s2_data0_q : s1_data0_q;
    assign bus.dout0_vld = (READ_LATENCY == 2) ? s2_vld0_q  : s1_vld0_q;
    assign bus.dout1     = (READ_LATENCY == 2) ? s2_data1_q : s1_data1_q;
    assign bus.dout1_vld = (READ_LATENCY == 2) ? s2_vld1_q  : s1_vld1_q;
    assign bus.collision = (READ_LATENCY == 2) ? s2_col_q   : s1_col_q;

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Directed bench: dut_a is latency 1 with forwarding, dut_b is latency 2 returning old data on collision.
module tb_sram_1rw1r_param;

    logic clk0;
    logic rstb0;
    int   checks;
    int   errors;
    int   n;
    int   vld_seen;

    sram_1rw1r_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_WMASKS(4)) bus_a ();
    sram_1rw1r_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_WMASKS(4)) bus_b ();

    sram_1rw1r_param #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .WMASK_GRAN(8),
        .READ_LATENCY(1), .WR_FWD(1), .CLEAR_ON_RESET(1)
    ) dut_a (
        .clk0  (clk0),
        .rstb0 (rstb0),
        .bus   (bus_a.slave)
    );

    sram_1rw1r_param #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .WMASK_GRAN(8),
        .READ_LATENCY(2), .WR_FWD(0), .CLEAR_ON_RESET(1)
    ) dut_b (
        .clk0  (clk0),
        .rstb0 (rstb0),
        .bus   (bus_b.slave)
    );

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic apply_stimulus(input logic cs0_n, input logic we0_n, input logic [3:0] mask,
                                  input logic [7:0] a0, input logic [31:0] d0,
                                  input logic cs1_n, input logic [7:0] a1);
        bus_a.csb0 = cs0_n; bus_a.web0 = we0_n; bus_a.wmask0 = mask;
        bus_a.addr0 = a0;   bus_a.din0 = d0;    bus_a.csb1 = cs1_n; bus_a.addr1 = a1;
        bus_b.csb0 = cs0_n; bus_b.web0 = we0_n; bus_b.wmask0 = mask;
        bus_b.addr0 = a0;   bus_b.din0 = d0;    bus_b.csb1 = cs1_n; bus_b.addr1 = a1;
    endtask

    task automatic idle();
        apply_stimulus(1'b1, 1'b1, 4'h0, 8'h00, 32'h0, 1'b1, 8'h00);
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstb0  = 1'b0;
        idle();
        repeat (3) tick();

        $display("[TB] reset state");
        check_output("rst_a_dout0", bus_a.dout0, 32'h0);
        check_output("rst_a_dout1", bus_a.dout1, 32'h0);
        check_bit("rst_a_vld0", bus_a.dout0_vld, 1'b0);
        check_bit("rst_a_vld1", bus_a.dout1_vld, 1'b0);
        check_bit("rst_a_coll", bus_a.collision, 1'b0);
        check_bit("rst_a_init", bus_a.init_done, 1'b0);
        check_bit("rst_b_init", bus_b.init_done, 1'b0);

        // Interrupt the first clear at ptr=100, then issue requests through the restarted clear.
        rstb0 = 1'b1;
        repeat (100) tick();
        check_bit("midclear_init", bus_a.init_done, 1'b0);
        rstb0 = 1'b0;
        tick();
        rstb0 = 1'b1;
        apply_stimulus(1'b0, 1'b0, 4'hF, 8'h05, 32'hFFFF_FFFF, 1'b0, 8'h05);
        n        = 0;
        vld_seen = 0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            n = i;
            if (bus_a.dout0_vld || bus_a.dout1_vld || bus_b.dout1_vld || bus_a.collision) vld_seen++;
            if (bus_a.init_done) break;
        end
        idle();
        $display("[TB] init_done after %0d cycles", n);
        check_output("init_cycles", 32'(n), 32'd256);
        check_output("clear_vld_count", 32'(vld_seen), 32'd0);
        check_bit("init_b", bus_b.init_done, 1'b1);

        apply_stimulus(1'b1, 1'b1, 4'h0, 8'h05, 32'h0, 1'b0, 8'hFF);
        bus_a.csb0 = 1'b0; bus_b.csb0 = 1'b0;
        tick();
        idle();
        check_output("clr_a_dout0", bus_a.dout0, 32'h0);
        check_bit("clr_a_vld0", bus_a.dout0_vld, 1'b1);
        check_output("clr_a_dout1", bus_a.dout1, 32'h0);
        check_bit("clr_a_vld1", bus_a.dout1_vld, 1'b1);
        check_bit("clr_b_vld1_early", bus_b.dout1_vld, 1'b0);
        tick();
        check_bit("clr_a_vld0_drop", bus_a.dout0_vld, 1'b0);
        check_bit("clr_b_vld1", bus_b.dout1_vld, 1'b1);
        check_output("clr_b_dout1", bus_b.dout1, 32'h0);

        $display("[TB] masked write");
        apply_stimulus(1'b0, 1'b0, 4'hF, 8'h12, 32'h1122_3344, 1'b1, 8'h00);
        tick();
        apply_stimulus(1'b0, 1'b0, 4'b0101, 8'h12, 32'hAABB_CCDD, 1'b1, 8'h00);
        tick();
        check_bit("wr_no_vld0", bus_a.dout0_vld, 1'b0);
        apply_stimulus(1'b0, 1'b0, 4'h0, 8'h12, 32'hFFFF_FFFF, 1'b1, 8'h00);
        tick();
        apply_stimulus(1'b0, 1'b1, 4'h0, 8'h12, 32'h0, 1'b1, 8'h00);
        tick();
        idle();
        check_output("mask_a_dout0", bus_a.dout0, 32'h11BB_33DD);
        check_bit("mask_a_vld0", bus_a.dout0_vld, 1'b1);
        tick();
        check_bit("mask_a_vld0_drop", bus_a.dout0_vld, 1'b0);
        check_output("mask_a_hold", bus_a.dout0, 32'h11BB_33DD);
        check_output("mask_b_dout0", bus_b.dout0, 32'h11BB_33DD);
        check_bit("mask_b_vld0", bus_b.dout0_vld, 1'b1);

        $display("[TB] collision");
        apply_stimulus(1'b0, 1'b0, 4'hF, 8'h05, 32'hDEAD_BEEF, 1'b0, 8'h05);
        tick();
        idle();
        check_output("col_a_dout1", bus_a.dout1, 32'hDEAD_BEEF);
        check_bit("col_a_flag", bus_a.collision, 1'b1);
        check_bit("col_b_early", bus_b.collision, 1'b0);
        tick();
        check_bit("col_a_flag_drop", bus_a.collision, 1'b0);
        check_output("col_b_dout1", bus_b.dout1, 32'h0);
        check_bit("col_b_vld1", bus_b.dout1_vld, 1'b1);
        check_bit("col_b_flag", bus_b.collision, 1'b1);
        apply_stimulus(1'b0, 1'b0, 4'b0011, 8'h05, 32'h0000_0000, 1'b0, 8'h05);
        tick();
        idle();
        check_output("pcol_a_dout1", bus_a.dout1, 32'hDEAD_0000);
        check_bit("pcol_a_flag", bus_a.collision, 1'b1);
        tick();
        check_output("pcol_b_dout1", bus_b.dout1, 32'hDEAD_BEEF);
        apply_stimulus(1'b1, 1'b1, 4'h0, 8'h00, 32'h0, 1'b0, 8'h05);
        tick();
        idle();
        check_output("postcol_a_dout1", bus_a.dout1, 32'hDEAD_0000);
        tick();
        check_output("postcol_b_dout1", bus_b.dout1, 32'hDEAD_0000);

        $display("[TB] streaming port-1 reads");
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b0, 1'b0, 4'hF, 8'(i), 32'h1000_0000 + 32'(i), 1'b1, 8'h00);
            tick();
        end
        for (int k = 1; k <= 10; k++) begin
            if (k <= 8) apply_stimulus(1'b1, 1'b1, 4'h0, 8'h00, 32'h0, 1'b0, 8'(k - 1));
            else        idle();
            tick();
            check_bit($sformatf("strm_a_vld_%0d", k), bus_a.dout1_vld, k <= 8);
            if (k <= 8) check_output($sformatf("strm_a_dout_%0d", k), bus_a.dout1, 32'h1000_0000 + 32'(k - 1));
            check_bit($sformatf("strm_b_vld_%0d", k), bus_b.dout1_vld, (k >= 2) && (k <= 9));
            if ((k >= 2) && (k <= 9))
                check_output($sformatf("strm_b_dout_%0d", k), bus_b.dout1, 32'h1000_0000 + 32'(k - 2));
        end

        apply_stimulus(1'b0, 1'b1, 4'h0, 8'h07, 32'h0, 1'b0, 8'h07);
        tick();
        idle();
        check_output("dual_a_dout0", bus_a.dout0, 32'h1000_0007);
        check_output("dual_a_dout1", bus_a.dout1, 32'h1000_0007);
        check_bit("dual_a_coll", bus_a.collision, 1'b0);
        tick();
        check_output("dual_b_dout0", bus_b.dout0, 32'h1000_0007);
        check_output("dual_b_dout1", bus_b.dout1, 32'h1000_0007);
        check_bit("dual_b_coll", bus_b.collision, 1'b0);

        $display("[TB] hold behaviour");
        apply_stimulus(1'b0, 1'b0, 4'hF, 8'h20, 32'hCAFE_F00D, 1'b1, 8'h00);
        tick();
        apply_stimulus(1'b0, 1'b1, 4'h0, 8'h20, 32'h0, 1'b1, 8'h00);
        tick();
        idle();
        check_output("hold_a_read", bus_a.dout0, 32'hCAFE_F00D);
        tick();
        check_bit("hold_a_vld0", bus_a.dout0_vld, 1'b0);
        check_output("hold_a_idle", bus_a.dout0, 32'hCAFE_F00D);
        check_output("hold_b_read", bus_b.dout0, 32'hCAFE_F00D);
        apply_stimulus(1'b0, 1'b0, 4'hF, 8'h21, 32'h1234_5678, 1'b1, 8'h00);
        tick();
        idle();
        check_output("hold_a_wr", bus_a.dout0, 32'hCAFE_F00D);
        check_bit("hold_a_wr_vld0", bus_a.dout0_vld, 1'b0);
        tick();
        check_output("hold_b_wr", bus_b.dout0, 32'hCAFE_F00D);
        check_bit("hold_b_wr_vld0", bus_b.dout0_vld, 1'b0);
        apply_stimulus(1'b0, 1'b1, 4'h0, 8'h21, 32'h0, 1'b1, 8'h00);
        tick();
        idle();
        check_output("hold_a_readback", bus_a.dout0, 32'h1234_5678);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
